// File: rtl/rv_core_sequencer.sv
// rv_core_sequencer
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the RV32IM core.
// Owns the program counter, handshakes with instruction memory and the
// execute unit, and allows exactly one register-file write per retired
// instruction. It traps on out-of-range branch targets.
// Optional feature macro: SEQ_WATCHDOG_EN adds an execute-stage watchdog
// that traps with cause 1 when the execute unit never answers.
module rv_core_sequencer #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IMEM_ADDR_W = 8,
  parameter int unsigned PC_STEP     = 1,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic                   imem_valid,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            ins,
  output logic                   ex_start,
  input  logic                   ex_ready,
  input  logic [XLEN-1:0]        ex_result,
  input  logic                   regwen_in,
  input  logic                   branch_taken,
  input  logic [XLEN-1:0]        branch_target,
  output logic [XLEN-1:0]        pc,
  output logic                   rf_we,
  output logic [XLEN-1:0]        rf_wdata,
  output logic [XLEN-1:0]        retired,
  output logic                   trap,
  output logic [1:0]             trap_cause
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_BRANCH = 2'd2;

  state_t state_q;
  state_t state_d;

  // High only during the first EXECUTE cycle, when ex_ready is not yet trusted.
  logic ex_first_q;
  // Register-write enable captured with the result so rf_we has no input path.
  logic regwen_q;
  logic ex_accept;
  logic target_oor;
  logic wb_trap;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WDOG_W     = $clog2(WDOG_CYCLES + 1);
  localparam logic [1:0]  CAUSE_WDOG = 2'd1;

  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_trip;

  // Counts completed EXECUTE cycles; cleared in DECODE so it starts at zero on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q <= '0;
    end else if (state_q == DECODE) begin
      wdog_cnt_q <= '0;
    end else if (state_q == EXECUTE) begin
      wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
    end
  end

  // Trips in the cycle that would bring the count to the limit.
  assign wdog_trip = (state_q == EXECUTE) &&
                     (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
`endif

  // Result is accepted from the second EXECUTE cycle onward; a late ready beats the watchdog.
  assign ex_accept  = (state_q == EXECUTE) && !ex_first_q && ex_ready;
  assign target_oor = ((branch_target >> IMEM_ADDR_W) != '0);
  assign wb_trap    = branch_taken && target_oor;
  assign imem_addr  = pc[IMEM_ADDR_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; strobes depend only on registered state.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ex_start = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = EXECUTE;
      end
      EXECUTE: begin
        ex_start = ex_first_q;
        if (ex_accept) begin
          state_d = WRITEBACK;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wdog_trip) begin
          state_d = TRAP;
        end
`endif
      end
      WRITEBACK: begin
        rf_we = regwen_q;
        if (wb_trap) begin
          state_d = TRAP;
        end else if (run) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Architectural state: instruction latch, write data, PC, retire count and trap record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_first_q <= 1'b0;
      regwen_q   <= 1'b0;
      ins        <= '0;
      rf_wdata   <= '0;
      pc         <= XLEN'(RESET_PC);
      retired    <= '0;
      trap       <= 1'b0;
      trap_cause <= '0;
    end else begin
      ex_first_q <= (state_q == DECODE);
      if ((state_q == FETCH) && imem_valid) begin
        ins <= imem_rdata;
      end
      if (ex_accept) begin
        rf_wdata <= ex_result;
        regwen_q <= regwen_in;
      end
      if (state_q == WRITEBACK) begin
        if (wb_trap) begin
          trap       <= 1'b1;
          trap_cause <= CAUSE_BRANCH;
        end else begin
          pc      <= branch_taken ? branch_target : (pc + XLEN'(PC_STEP));
          retired <= retired + XLEN'(1);
        end
      end
`ifdef SEQ_WATCHDOG_EN
      if (wdog_trip && !ex_accept) begin
        trap       <= 1'b1;
        trap_cause <= CAUSE_WDOG;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rv_core_sequencer.sv
// Directed testbench for rv_core_sequencer: sequential issue, register-write
// gating, memory stall, branching, run control, reset mid-instruction and
// out-of-range branch trap. Watchdog cases are built when SEQ_WATCHDOG_EN is defined.
module tb_rv_core_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ex_start;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic        regwen_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [31:0] retired;
  logic        trap;
  logic [1:0]  trap_cause;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] expPc;
  logic [31:0] expRetired;

  rv_core_sequencer #(
    .XLEN(32), .IMEM_ADDR_W(8), .PC_STEP(1), .RESET_PC(0), .WDOG_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .ins(ins), .ex_start(ex_start), .ex_ready(ex_ready), .ex_result(ex_result),
    .regwen_in(regwen_in), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .rf_we(rf_we), .rf_wdata(rf_wdata), .retired(retired),
    .trap(trap), .trap_cause(trap_cause)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Holds reset for a cycle, releases it and resets the reference model.
  task automatic applyReset();
    rst = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    ex_ready = 1'b0; ex_result = '0; regwen_in = 1'b1;
    branch_taken = 1'b0; branch_target = '0;
    tick();
    rst = 1'b1;
    tick();
    expPc = 32'd0;
    expRetired = 32'd0;
  endtask

  // Drives one instruction starting in FETCH and checks every stage along the way.
  task automatic applyStimulus(input int memWait, input int exExtra, input logic [31:0] insWord,
                               input logic [31:0] result, input logic regwen, input logic taken,
                               input logic [31:0] target, input logic runAfter);
    logic oor;
    regwen_in = regwen;
    for (int w = 0; w < memWait; w++) begin
      imem_valid = 1'b0;
      checkOutput("stall_req", {31'b0, imem_req}, 32'd1);
      checkOutput("stall_addr", {24'b0, imem_addr}, {24'b0, expPc[7:0]});
      checkOutput("stall_no_start", {31'b0, ex_start}, 32'd0);
      tick();
    end
    checkOutput("fetch_req", {31'b0, imem_req}, 32'd1);
    checkOutput("fetch_addr", {24'b0, imem_addr}, {24'b0, expPc[7:0]});
    imem_valid = 1'b1;
    imem_rdata = insWord;
    tick();
    imem_valid = 1'b0;
    checkOutput("decode_ins", ins, insWord);
    checkOutput("decode_req", {31'b0, imem_req}, 32'd0);
    tick();
    checkOutput("exec_start", {31'b0, ex_start}, 32'd1);
    ex_ready = 1'b1;
    ex_result = 32'hDEAD_BEEF;
    tick();
    for (int e = 0; e < exExtra; e++) begin
      ex_ready = 1'b0;
      checkOutput("exec_hold_start", {31'b0, ex_start}, 32'd0);
      checkOutput("exec_no_we", {31'b0, rf_we}, 32'd0);
      tick();
    end
    checkOutput("exec_no_restart", {31'b0, ex_start}, 32'd0);
    ex_ready = 1'b1;
    ex_result = result;
    run = runAfter;
    tick();
    ex_ready = 1'b0;
    ex_result = '0;
    checkOutput("wb_we", {31'b0, rf_we}, {31'b0, regwen});
    checkOutput("wb_wdata", rf_wdata, result);
    checkOutput("wb_pc_hold", pc, expPc);
    branch_taken = taken;
    branch_target = target;
    tick();
    branch_taken = 1'b0;
    branch_target = '0;
    oor = taken && (target[31:8] != 24'd0);
    if (!oor) begin
      expPc = taken ? target : expPc + 32'd1;
      expRetired = expRetired + 32'd1;
    end
    checkOutput("post_pc", pc, expPc);
    checkOutput("post_retired", retired, expRetired);
    checkOutput("post_we_low", {31'b0, rf_we}, 32'd0);
    checkOutput("post_trap", {31'b0, trap}, {31'b0, oor});
    checkOutput("post_cause", {30'b0, trap_cause}, oor ? 32'd2 : 32'd0);
    checkOutput("post_req", {31'b0, imem_req}, {31'b0, (!oor && runAfter)});
  endtask

  // Directed scenario sequence.
  initial begin
    rst = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    ex_ready = 1'b0; ex_result = '0; regwen_in = 1'b1;
    branch_taken = 1'b0; branch_target = '0;
    expPc = 32'd0; expRetired = 32'd0;
    tick();
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_ins", ins, 32'd0);
    checkOutput("rst_wdata", rf_wdata, 32'd0);
    checkOutput("rst_retired", retired, 32'd0);
    checkOutput("rst_trap", {31'b0, trap}, 32'd0);
    checkOutput("rst_cause", {30'b0, trap_cause}, 32'd0);
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_start", {31'b0, ex_start}, 32'd0);
    checkOutput("rst_we", {31'b0, rf_we}, 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("idle_req", {31'b0, imem_req}, 32'd0);

    // Sequential run, then a non-writing instruction and a slow MUL-like one.
    run = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h0000_0013 + (i << 7), 32'h100 + i, 1'b1, 1'b0, 32'd0, 1'b1);
    end
    checkOutput("seq_retired3", retired, 32'd3);
    applyStimulus(0, 0, 32'h0000_0063, 32'h0000_0555, 1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(0, 2, 32'h02B5_0533, 32'h1234_5678, 1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("seq_pc5", pc, 32'd5);

    // In-range branch at pc 5, then a stalled fetch with run dropped during EXECUTE.
    applyStimulus(0, 0, 32'h0000_006F, 32'h0000_0006, 1'b1, 1'b1, 32'h40, 1'b1);
    checkOutput("branch_addr", {24'b0, imem_addr}, 32'h40);
    applyStimulus(3, 0, 32'h0000_0093, 32'hCAFE_0001, 1'b1, 1'b0, 32'd0, 1'b0);
    tick();
    checkOutput("idle_after_run0", {31'b0, imem_req}, 32'd0);
    checkOutput("idle_pc", pc, 32'h41);

    // Reset asserted in the middle of EXECUTE discards the instruction.
    run = 1'b1;
    tick();
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    checkOutput("mid_start", {31'b0, ex_start}, 32'd1);
    tick();
    rst = 1'b0;
    #2;
    checkOutput("mid_rst_pc", pc, 32'd0);
    checkOutput("mid_rst_retired", retired, 32'd0);
    checkOutput("mid_rst_we", {31'b0, rf_we}, 32'd0);
    checkOutput("mid_rst_req", {31'b0, imem_req}, 32'd0);
    ex_ready = 1'b1;
    tick();
    checkOutput("mid_rst_we_hold", {31'b0, rf_we}, 32'd0);
    ex_ready = 1'b0;
    run = 1'b0;
    rst = 1'b1;
    expPc = 32'd0;
    expRetired = 32'd0;
    tick();
    checkOutput("mid_rst_idle", {31'b0, imem_req}, 32'd0);

    // Out-of-range branch target at pc 5 traps and holds.
    run = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 32'h0000_0013, 32'h10 + i, 1'b1, 1'b0, 32'd0, 1'b1);
    end
    applyStimulus(0, 0, 32'h0000_006F, 32'h0000_0777, 1'b1, 1'b1, 32'h100, 1'b1);
    tick();
    tick();
    checkOutput("trap_sticky", {31'b0, trap}, 32'd1);
    checkOutput("trap_pc", pc, 32'd5);
    checkOutput("trap_retired", retired, 32'd5);
    checkOutput("trap_req", {31'b0, imem_req}, 32'd0);

`ifdef SEQ_WATCHDOG_EN
    // Execute unit never answers: trap after the fourth EXECUTE cycle.
    applyReset();
    run = 1'b1;
    tick();
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    ex_ready = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("wdog_pre_trap", {31'b0, trap}, 32'd0);
    tick();
    checkOutput("wdog_trap", {31'b0, trap}, 32'd1);
    checkOutput("wdog_cause", {30'b0, trap_cause}, 32'd1);
    checkOutput("wdog_we", {31'b0, rf_we}, 32'd0);
    checkOutput("wdog_retired", retired, 32'd0);

    // Ready arriving on the fourth EXECUTE cycle is still accepted.
    applyReset();
    run = 1'b1;
    tick();
    applyStimulus(0, 2, 32'h0000_0013, 32'h0000_ABCD, 1'b1, 1'b0, 32'd0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rv_core_sequencer.md
# rv_core_sequencer

Parametrised multi-cycle instruction sequencer for the RV32IM core, replacing the free-running PC and the PC-change-reset ALU scheme with an explicit FETCH/DECODE/EXECUTE/WRITEBACK state machine. It owns the program counter and handshakes with instruction memory and the execute unit (ALU/MUL/DIV). It gates register-file writes to exactly one per retired instruction and traps on out-of-range branch targets and, optionally, on execute timeouts.

## Interface
- XLEN, 32, datapath and PC width
- IMEM_ADDR_W, 8, instruction memory address width (word addressed)
- PC_STEP, 1, PC increment per sequential instruction
- RESET_PC, 0, PC value after reset
- WDOG_CYCLES, 64, execute watchdog limit (only with SEQ_WATCHDOG_EN)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- run  input  1  1 = keep issuing instructions; 0 = stop in IDLE after the current instruction
- imem_req  output  1  fetch request
- imem_addr  output  IMEM_ADDR_W  fetch address = pc[IMEM_ADDR_W-1:0]
- imem_valid  input  1  fetch data valid
- imem_rdata  input  32  fetched instruction
- ins  output  32  latched current instruction
- ex_start  output  1  one-cycle start pulse to execute unit
- ex_ready  input  1  execute result valid
- ex_result  input  XLEN  execute result
- regwen_in  input  1  decoded register write enable
- branch_taken  input  1  branch decision for current instruction
- branch_target  input  XLEN  branch destination
- pc  output  XLEN  current PC
- rf_we  output  1  register-file write strobe
- rf_wdata  output  XLEN  register-file write data
- retired  output  XLEN  retired-instruction counter
- trap  output  1  sticky trap flag
- trap_cause  output  2  0 none, 1 watchdog, 2 branch target out of range

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- IDLE: run=1 → FETCH; otherwise stay.
- FETCH: imem_req=1. On imem_valid, latch imem_rdata into ins → DECODE; otherwise stay with imem_req held high and imem_addr stable.
- DECODE: one cycle; control/immediate logic settles on ins → EXECUTE.
- EXECUTE: ex_start=1 in the first EXECUTE cycle only. ex_ready is ignored in that cycle and sampled from the next cycle on. On ex_ready, latch ex_result into rf_wdata → WRITEBACK.
- WRITEBACK:
  - rf_we = regwen_in for exactly one cycle.
  - If branch_taken and branch_target[XLEN-1:IMEM_ADDR_W] != 0: rf_we still follows regwen_in, pc unchanged, retired unchanged, trap_cause=2 → TRAP.
  - Otherwise pc ← branch_taken ? branch_target : pc+PC_STEP (modulo 2^XLEN), retired ← retired+1 (wraps), then → FETCH if run=1, else IDLE.
- TRAP: all strobes low, trap=1; left only via reset.
- run is sampled only in IDLE and WRITEBACK. Deasserting run mid-instruction never aborts it.
- Reset values (async, on rst=0): state IDLE, pc=RESET_PC, ins=0, rf_wdata=0, retired=0, trap=0, trap_cause=0. All strobes (imem_req, ex_start, rf_we) are 0. Reset mid-instruction discards it with no rf_we.

## Timing
- With zero-wait memory and ex_ready asserted one cycle after ex_start, each instruction takes 5 cycles: FETCH 1, DECODE 1, EXECUTE 2, WRITEBACK 1.
- Each imem wait cycle adds 1. Each extra execute cycle (MUL/DIV) adds 1.
- imem_req, imem_addr, ex_start and rf_we are registered-state decodes with no combinational path from any input.
- pc and retired update on the clock edge that ends WRITEBACK. The new pc is visible on imem_addr in the next FETCH.
- rf_wdata is stable from the edge that ends EXECUTE through the end of WRITEBACK.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A counter clears on entry to EXECUTE and increments each EXECUTE cycle.
  - If it reaches WDOG_CYCLES without ex_ready → TRAP with trap_cause=1 and no rf_we.
  - If ex_ready arrives in the same cycle the counter reaches the limit, the result is accepted and no trap is raised.
- SEQ_WATCHDOG_EN undefined: EXECUTE waits indefinitely, no counter logic exists, and trap_cause=1 is unreachable.

## Test plan
- Sequential run: RESET_PC=0, run=1, zero-wait imem, ex_ready one cycle after ex_start, regwen_in=1 → pc steps 0,1,2,… every 5 cycles; rf_we pulses once per instruction; retired=3 after 15 cycles.
- Memory stall: imem_valid delayed 3 cycles → imem_req and imem_addr held stable throughout; instruction takes 8 cycles; no extra ex_start.
- Branch: branch_taken=1, branch_target=0x40 at pc=5 → next imem_addr=0x40. branch_target=0x100 with IMEM_ADDR_W=8 → trap=1, trap_cause=2, pc stays 5, retired unchanged.
- Run control and reset: run dropped during EXECUTE → instruction completes, then IDLE with imem_req=0. rst pulsed low mid-EXECUTE → immediate IDLE, pc=RESET_PC, no rf_we.
- Watchdog (SEQ_WATCHDOG_EN, WDOG_CYCLES=4): ex_ready never asserted → trap_cause=1 after 4 EXECUTE cycles, no rf_we. ex_ready on the 4th cycle → normal writeback, no trap.
